pattern_serializer_tx: RTL and testbench
========================================

# pattern_serializer_tx

Serial pattern transmitter: accepts a parallel bit pattern of programmable length over a valid/ready load interface and drives it out MSB-first, one bit per clock, on a single serial line. It is the source end of the serial bit-stream interface consumed by the sequence-detector FSMs in the `fsms` tree (e.g. the 101 detector's `x` input). It sits between a test or control master and any detector, and it supports gap-free back-to-back frames.

## Interface
- `WIDTH`, default 8: maximum pattern length in bits (≥2).
- `LEN_W`, default `$clog2(WIDTH+1)`: width of the length field.
- `clk`  in  1  single clock; all logic on posedge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `load_valid`  in  1  master offers a pattern.
- `load_ready`  out  1  block accepts the pattern this cycle.
- `load_data`  in  WIDTH  pattern; bits `[load_len-1:0]` are significant.
- `load_len`  in  LEN_W  number of bits to send, 1..WIDTH.
- `x_out`  out  1  serial data bit.
- `x_valid`  out  1  `x_out` carries a frame bit this cycle.
- `x_last`  out  1  current bit is the final bit of the frame.
- `busy`  out  1  frame in progress (equals `x_valid`).
- `repeat_en`  in  1  present only with `PATTERN_SERIALIZER_REPEAT_EN`.

## Operation
- States: `IDLE`, `SHIFT`.
- Accept condition: `load_valid & load_ready` at a posedge. `load_ready` = `IDLE` | (`SHIFT` & `x_last`).
- On accept: shift register ← `load_data << (WIDTH-load_len)`, left-aligned. Bit counter ← `load_len`. State → `SHIFT`.
- In `SHIFT`: `x_out` = shift register MSB. Each cycle the register shifts left by 1 (zero fill) and the counter decrements. `x_last` = (counter == 1).
- On the last bit:
  - Accept present → reload; next cycle is the new frame's first bit, with no gap.
  - Otherwise → `IDLE`.
- `load_len` = 0 or > WIDTH: the handshake completes, but the request is dropped. State is unchanged and no bits are sent.
- `load_valid` high while not ready: no effect; the master holds its data.
- All outputs are registered or decoded from registered state only. There is no combinational path from `load_*` to `x_*`.

## Timing
- Reset (`reset_n` low at a posedge): state `IDLE`, shift register 0, counter 0, `x_out`=0, `x_valid`=0, `x_last`=0, `busy`=0. `load_ready`=1 from the first cycle after reset.
- Reset mid-frame: the frame is aborted at that edge. No further bits and no `x_last`.
- Latency: accept at edge N → first bit valid in cycle N+1. Last bit is in cycle N+len, with `x_last` high only in that cycle.
- len=1: `x_valid` and `x_last` are both high in cycle N+1.
- Throughput: one bit per clock, back-to-back frames at 100 % line utilisation.

## Configuration
- `PATTERN_SERIALIZER_REPEAT_EN` defined:
  - Adds the `repeat_en` input and a held copy of the last accepted data and length.
  - On the last bit, if no new accept occurs and `repeat_en`=1, the held pattern reloads and streams again with no gap.
  - A new accept takes priority over repeat.
  - `repeat_en` is sampled only on the last-bit cycle.
  - Reset clears the held copy.
- Not defined: no port and no held registers. A frame ends in `IDLE` unless a new load is accepted.

## Structure
- Shared package `pattern_serializer_pkg`:
  - State encoding localparams (`IDLE`=1'b0, `SHIFT`=1'b1).
  - Default `WIDTH`.
  - `LEN_W` derivation function.
- Sub-module `frame_bit_counter`: loadable LEN_W down-counter. Inputs: load, load value, decrement enable. Outputs: `is_last`, `is_zero`, each with synchronous active-low reset.

## Test plan
- WIDTH=8, reset, then load `8'h05` len 3 at edge N → `x_out` 1,0,1 in cycles N+1..N+3. `x_last` high only at N+3. A downstream 101 detector raises `y` in cycle N+3.
- Back-to-back: `8'hA5` len 8, then `8'h03` len 2 offered during the last bit → stream 1010_0101_11 with `x_valid` continuously high for 10 cycles.
- Edge lengths: len=1 data `8'h01` → single bit 1 with `x_valid` and `x_last` together. len=0 → accepted, `x_valid` stays 0.
- `load_valid` held during a frame → `load_ready` low until the last-bit cycle. Data changes before accept are ignored.
- Reset asserted at bit 4 of an 8-bit frame → next cycle all outputs 0, `load_ready`=1. A new 3-bit load streams correctly.
- With `PATTERN_SERIALIZER_REPEAT_EN`: `8'h05` len 3, `repeat_en`=1 → 101101101… continuous. Drop `repeat_en` mid-frame → the current frame finishes, then `IDLE`.

Source files
------------

// File: rtl/pattern_serializer_pkg.sv
// Shared definitions for the pattern serializer: state encoding, default width
// and the length-field width derivation.
package pattern_serializer_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic IDLE  = 1'b0;
   localparam logic SHIFT = 1'b1;

   typedef enum logic {
      ST_IDLE  = IDLE,
      ST_SHIFT = SHIFT
   } state_e;

   // Length field must be able to hold the value WIDTH itself.
   function automatic int calc_len_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/frame_bit_counter.sv
// Loadable down-counter tracking the bits left in the current frame, with
// registered last-bit and zero flags.
module frame_bit_counter #(
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [LEN_W-1:0] load_val,
   input  logic             dec,
   output logic             is_last,
   output logic             is_zero
);

   logic [LEN_W-1:0] cnt_r;
   logic [LEN_W-1:0] cnt_next_s;

   // next count: load wins over decrement, decrement saturates at zero
   always_comb begin
      cnt_next_s = cnt_r;
      if (load) begin
         cnt_next_s = load_val;
      end else if (dec && (cnt_r != {LEN_W{1'b0}})) begin
         cnt_next_s = cnt_r - LEN_W'(1);
      end else begin
         cnt_next_s = cnt_r;
      end
   end

   // count register and flags decoded from the next count
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_r   <= {LEN_W{1'b0}};
         is_last <= 1'b0;
         is_zero <= 1'b1;
      end else begin
         cnt_r   <= cnt_next_s;
         is_last <= (cnt_next_s == LEN_W'(1));
         is_zero <= (cnt_next_s == {LEN_W{1'b0}});
      end
   end

endmodule

// File: rtl/pattern_serializer_tx.sv
// MSB-first serial pattern transmitter with gap-free back-to-back frames.
// Optional frame repeat is enabled by defining PATTERN_SERIALIZER_REPEAT_EN.
module pattern_serializer_tx
   import pattern_serializer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int LEN_W = calc_len_w(WIDTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic [LEN_W-1:0] load_len,
`ifdef PATTERN_SERIALIZER_REPEAT_EN
   input  logic             repeat_en,
`endif
   output logic             x_out,
   output logic             x_valid,
   output logic             x_last,
   output logic             busy
);

   state_e           state_r;
   state_e           state_next_s;
   logic [WIDTH-1:0] shift_r;
   logic [WIDTH-1:0] shift_next_s;
   logic [WIDTH-1:0] aligned_s;
   logic             len_ok_s;
   logic             take_s;
   logic             cnt_load_s;
   logic [LEN_W-1:0] cnt_load_val_s;
   logic             cnt_dec_s;
   logic             cnt_is_last_s;
   logic             cnt_is_zero_s;

`ifdef PATTERN_SERIALIZER_REPEAT_EN
   logic [WIDTH-1:0] held_data_r;
   logic [LEN_W-1:0] held_len_r;
`endif

   // Outputs are pure decodes of registered state; no path from load_* to x_*.
   assign x_valid    = (state_r == ST_SHIFT);
   assign busy       = x_valid;
   assign x_last     = x_valid & cnt_is_last_s;
   assign x_out      = x_valid & shift_r[WIDTH-1];
   assign load_ready = ~x_valid | x_last;

   // Illegal lengths still complete the handshake but never start a frame.
   assign len_ok_s  = (load_len != {LEN_W{1'b0}}) && (load_len <= LEN_W'(WIDTH));
   assign take_s    = load_valid & load_ready & len_ok_s;
   assign aligned_s = load_data << (LEN_W'(WIDTH) - load_len);

   frame_bit_counter #(
      .LEN_W (LEN_W)
   ) u_counter (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (cnt_load_s),
      .load_val (cnt_load_val_s),
      .dec      (cnt_dec_s),
      .is_last  (cnt_is_last_s),
      .is_zero  (cnt_is_zero_s)
   );

   // next-state, shift register and counter control
   always_comb begin
      state_next_s   = state_r;
      shift_next_s   = shift_r;
      cnt_load_s     = 1'b0;
      cnt_load_val_s = load_len;
      cnt_dec_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (take_s) begin
               state_next_s = ST_SHIFT;
               shift_next_s = aligned_s;
               cnt_load_s   = 1'b1;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            shift_next_s = {shift_r[WIDTH-2:0], 1'b0};
            cnt_dec_s    = ~cnt_is_zero_s;
            if (cnt_is_last_s) begin
               if (take_s) begin
                  shift_next_s = aligned_s;
                  cnt_load_s   = 1'b1;
`ifdef PATTERN_SERIALIZER_REPEAT_EN
               end else if (repeat_en) begin
                  shift_next_s   = held_data_r;
                  cnt_load_s     = 1'b1;
                  cnt_load_val_s = held_len_r;
`endif
               end else begin
                  state_next_s = ST_IDLE;
               end
            end else begin
               state_next_s = ST_SHIFT;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
            shift_next_s = {WIDTH{1'b0}};
         end
      endcase
   end

   // state and shift register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         shift_r <= {WIDTH{1'b0}};
      end else begin
         state_r <= state_next_s;
         shift_r <= shift_next_s;
      end
   end

`ifdef PATTERN_SERIALIZER_REPEAT_EN
   // held copy of the most recent legal pattern, replayed while repeat_en is high
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         held_data_r <= {WIDTH{1'b0}};
         held_len_r  <= {LEN_W{1'b0}};
      end else if (take_s) begin
         held_data_r <= aligned_s;
         held_len_r  <= load_len;
      end else begin
         held_data_r <= held_data_r;
         held_len_r  <= held_len_r;
      end
   end
`endif

endmodule

// File: tb/tb_pattern_serializer_tx.sv
// Scoreboard bench: the stimulus side expands each accepted pattern into its
// expected bit stream; a monitor pops and compares every presented bit.
module tb_pattern_serializer_tx;

   localparam int WIDTH = 8;
   localparam int LEN_W = 4;

   typedef struct packed {
      logic b;
      logic last;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             load_valid = 1'b0;
   logic             load_ready;
   logic [WIDTH-1:0] load_data = '0;
   logic [LEN_W-1:0] load_len = '0;
   logic             x_out, x_valid, x_last, busy;
`ifdef PATTERN_SERIALIZER_REPEAT_EN
   logic             repeat_en = 1'b0;
`endif

   int   tests = 0;
   int   fails = 0;
   exp_t exp_q[$];
   bit   accepted;

   pattern_serializer_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_len   (load_len),
`ifdef PATTERN_SERIALIZER_REPEAT_EN
      .repeat_en  (repeat_en),
`endif
      .x_out      (x_out),
      .x_valid    (x_valid),
      .x_last     (x_last),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every presented bit must be the next expected one; no gaps while bits are pending.
   always @(posedge clk) begin
      #1;
      if (reset_n) begin
         check("busy_eq_valid", busy, x_valid);
         if (x_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_bit", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("x_out", x_out, e.b);
               check("x_last", x_last, e.last);
            end
         end else begin
            check("gap_or_idle", exp_q.size(), 0);
            check("idle_x_out", x_out, 0);
            check("idle_x_last", x_last, 0);
         end
      end
   end

   // One stimulus cycle: drive at negedge, model the handshake, queue the expected bits.
   task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l);
      int n;
      @(negedge clk);
      load_valid = v;
      load_data  = d;
      load_len   = l;
      #1;
      check("load_ready", load_ready, (exp_q.size() == 0));
      accepted = v && (exp_q.size() == 0);
      n = int'(l);
      if (accepted && n >= 1 && n <= WIDTH) begin
         for (int i = n - 1; i >= 0; i--) begin
            exp_t e;
            e.b    = d[i];
            e.last = (i == 0);
            exp_q.push_back(e);
         end
      end
   endtask

   // Hold a request until the handshake completes (bounded).
   task automatic send(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l);
      int guard;
      guard = 0;
      do begin
         drive(1'b1, d, l);
         guard++;
      end while (!accepted && guard < 40);
      if (!accepted) check("send_timeout", 0, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n    = 1'b0;
      load_valid = 1'b0;
      exp_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("rst_x_valid", x_valid, 0);
      check("rst_x_out", x_out, 0);
      check("rst_x_last", x_last, 0);
      check("rst_busy", busy, 0);
      check("rst_load_ready", load_ready, 1);
   endtask

   initial begin
      logic [LEN_W-1:0] rl;
      int               r;
      int               guard;

      do_reset();

      send(8'h05, 4'd3);
      drive(1'b0, 8'h00, 4'd0);

      // back-to-back: second request waits for the last bit of the first
      send(8'hA5, 4'd8);
      send(8'h03, 4'd2);
      repeat (3) drive(1'b0, 8'h00, 4'd0);

      send(8'h01, 4'd1);
      drive(1'b0, 8'h00, 4'd0);
      send(8'hFF, 4'd0);
      send(8'hFF, 4'd12);
      repeat (3) drive(1'b0, 8'h00, 4'd0);

      // data changes while not ready must be ignored
      send(8'hC3, 4'd6);
      repeat (3) drive(1'b1, 8'($urandom), 4'd5);
      repeat (6) drive(1'b0, 8'h00, 4'd0);

      // reset mid-frame
      send(8'hA5, 4'd8);
      repeat (3) drive(1'b0, 8'h00, 4'd0);
      do_reset();
      send(8'h05, 4'd3);
      repeat (4) drive(1'b0, 8'h00, 4'd0);

      // random traffic, including illegal lengths
      for (int i = 0; i < 800; i++) begin
         r  = int'($urandom_range(0, 9));
         rl = (r < 8) ? LEN_W'(r + 1) : ((r == 8) ? 4'd0 : LEN_W'($urandom_range(9, 15)));
         drive(($urandom_range(0, 9) < 7), 8'($urandom), rl);
      end

      guard = 0;
      while (exp_q.size() != 0 && guard < 20) begin
         drive(1'b0, 8'h00, 4'd0);
         guard++;
      end
      check("drain", exp_q.size(), 0);
      drive(1'b0, 8'h00, 4'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
